operand_fetch: RTL and testbench
================================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the register width in bits.
REQ-002 SHALL have parameter NUM_REG, default 32, giving the register count; SELECT_WIDTH = $clog2(NUM_REG) is derived.
REQ-003 SHALL use one clock and an asynchronous active-low reset; nothing else is fixed by this requirement.
REQ-004 SHALL have the following ports:
- clk  in  1: rising-edge clock.
- rst_n  in  1: asynchronous active-low reset.
- i_reg_data  in  NUM_REG*DATA_WIDTH: flat register-bank contents; register k is in bits [k*DATA_WIDTH +: DATA_WIDTH].
- i_req_valid  in  1: request valid.
- o_req_ready  out  1: request ready.
- i_rs1_sel  in  SELECT_WIDTH: source 1 index.
- i_rs2_sel  in  SELECT_WIDTH: source 2 index.
- i_rd_en  in  1: request will write a destination.
- i_rd_sel  in  SELECT_WIDTH: destination index.
- i_wb_enable  in  1: writeback to the bank occurs this cycle.
- i_wb_select  in  SELECT_WIDTH: writeback index.
- i_wb_data  in  DATA_WIDTH: writeback data.
- o_op_valid  out  1: operand bundle valid.
- i_op_ready  in  1: consumer accepts the bundle.
- o_rs1_data  out  DATA_WIDTH: source 1 operand.
- o_rs2_data  out  DATA_WIDTH: source 2 operand.
- o_rd_en  out  1: registered copy of i_rd_en.
- o_rd_sel  out  SELECT_WIDTH: registered copy of i_rd_sel.
- o_busy  out  NUM_REG: scoreboard, one pending-write bit per register.

Function
REQ-005 A request SHALL be accepted on a rising edge where i_req_valid and o_req_ready are both high.
REQ-006 The output stage SHALL have two states:
- EMPTY (o_op_valid=0): goes to FULL on accept.
- FULL (o_op_valid=1): goes to EMPTY on i_op_ready without accept; stays FULL on i_op_ready with accept.
REQ-007 o_req_ready SHALL be high exactly when both hold:
- (o_op_valid=0 or i_op_ready=1); and
- no hazard exists.
REQ-008 A hazard SHALL exist when any of the following holds:
- o_busy[i_rs1_sel]=1;
- o_busy[i_rs2_sel]=1;
- i_rd_en=1 and o_busy[i_rd_sel]=1 (write-after-write).
REQ-009 Operands, o_rd_en and o_rd_sel SHALL be registered, appearing with o_op_valid the cycle after accept (latency 1).
REQ-010 Operands SHALL be taken from i_reg_data at the accepting edge.
REQ-011 While o_op_valid=1 and i_op_ready=0, all o_* bundle outputs SHALL hold stable.
REQ-012 On accept with i_rd_en=1, o_busy[i_rd_sel] SHALL set on the same edge.
REQ-013 When i_wb_enable=1, o_busy[i_wb_select] SHALL clear on that edge.
REQ-014 If a set and a clear target the same index on the same edge, set SHALL win.
REQ-015 A select >= NUM_REG SHALL read as zero and never cause a hazard.
REQ-016 A destination >= NUM_REG SHALL never set o_busy.
REQ-017 A writeback with i_wb_select >= NUM_REG SHALL be ignored.
REQ-018 The ready/valid path SHALL contain no combinational path from i_op_ready to o_op_valid.

Reset
REQ-019 While rst_n=0, all of the following SHALL be 0 asynchronously: o_op_valid, o_rs1_data, o_rs2_data, o_rd_en, o_rd_sel, o_busy.
REQ-020 Asserting rst_n=0 mid-operation SHALL discard the held bundle and all pending busy bits.
REQ-021 The first accept after reset SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-022 Macro OPERAND_FETCH_BYPASS_EN SHALL control writeback forwarding.
REQ-023 With OPERAND_FETCH_BYPASS_EN defined:
- a source whose busy bit is being cleared this cycle by i_wb_enable SHALL NOT be a hazard;
- its operand SHALL be taken from i_wb_data;
- REQ-008 write-after-write checking is unchanged.
REQ-024 Without OPERAND_FETCH_BYPASS_EN, such a source SHALL stall one cycle and then be read from i_reg_data.

Verification
REQ-025 Reset, then present rs1=3, rs2=5 with reg3=0x11, reg5=0x22 -> one cycle later o_op_valid=1, o_rs1_data=0x11, o_rs2_data=0x22.
REQ-026 Accept with rd_en=1, rd=7; next request has rs1=7 -> o_req_ready=0 until a wb to index 7; o_busy[7]=1 meanwhile.
REQ-027 Busy[7]=1, wb_enable=1, wb_select=7, wb_data=0xABCD, same cycle as a request with rs1=7 ->
- with BYPASS_EN: accepted that cycle, o_rs1_data=0xABCD;
- without BYPASS_EN: accepted next cycle.
REQ-028 Hold i_op_ready=0 for 3 cycles with o_op_valid=1 -> bundle stable and o_req_ready=0; raise i_op_ready with a new request pending -> back-to-back accept.
REQ-029 Same-edge accept with rd=4 and wb_select=4 -> o_busy[4]=1 afterwards.
REQ-030 Pull rst_n=0 while FULL with busy bits set -> o_op_valid=0 and o_busy=0 immediately.

Source files
------------

// File: rtl/operand_fetch.sv
// Operand fetch stage: scoreboard hazard check, register read, one-entry output bundle.
// Define OPERAND_FETCH_BYPASS_EN to forward same-cycle writeback data to a stalled source.
module operand_fetch #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REG = 32,
    localparam int SELECT_WIDTH = (NUM_REG > 1) ? $clog2(NUM_REG) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REG*DATA_WIDTH-1:0] i_reg_data,
    input  logic                          i_req_valid,
    output logic                          o_req_ready,
    input  logic [SELECT_WIDTH-1:0]       i_rs1_sel,
    input  logic [SELECT_WIDTH-1:0]       i_rs2_sel,
    input  logic                          i_rd_en,
    input  logic [SELECT_WIDTH-1:0]       i_rd_sel,
    input  logic                          i_wb_enable,
    input  logic [SELECT_WIDTH-1:0]       i_wb_select,
    input  logic [DATA_WIDTH-1:0]         i_wb_data,
    output logic                          o_op_valid,
    input  logic                          i_op_ready,
    output logic [DATA_WIDTH-1:0]         o_rs1_data,
    output logic [DATA_WIDTH-1:0]         o_rs2_data,
    output logic                          o_rd_en,
    output logic [SELECT_WIDTH-1:0]       o_rd_sel,
    output logic [NUM_REG-1:0]            o_busy
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t state;
    state_t state_n;

    logic [DATA_WIDTH-1:0] regs [NUM_REG];
    logic [NUM_REG-1:0]    busy_n;
    logic                  busy1;
    logic                  busy2;
    logic                  busy_d;
    logic                  fwd1;
    logic                  fwd2;
    logic                  hazard;
    logic                  accept;
    logic [DATA_WIDTH-1:0] rs1_val;
    logic [DATA_WIDTH-1:0] rs2_val;

    always_comb begin
        for (int k = 0; k < NUM_REG; k++) begin
            regs[k] = i_reg_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Out-of-range selects match no k, so they read zero and are never busy.
    function automatic logic busy_of(input logic [SELECT_WIDTH-1:0] sel,
                                     input logic [NUM_REG-1:0] b);
        busy_of = 1'b0;
        for (int k = 0; k < NUM_REG; k++) begin
            if (sel == SELECT_WIDTH'(k)) busy_of = b[k];
        end
    endfunction

    function automatic logic [DATA_WIDTH-1:0] read_of(
        input logic [SELECT_WIDTH-1:0] sel);
        read_of = '0;
        for (int k = 0; k < NUM_REG; k++) begin
            if (sel == SELECT_WIDTH'(k)) read_of = regs[k];
        end
    endfunction

    assign busy1  = busy_of(i_rs1_sel, o_busy);
    assign busy2  = busy_of(i_rs2_sel, o_busy);
    assign busy_d = busy_of(i_rd_sel, o_busy);

`ifdef OPERAND_FETCH_BYPASS_EN
    logic wb_hit1;
    logic wb_hit2;

    assign wb_hit1 = i_wb_enable && (i_wb_select == i_rs1_sel);
    assign wb_hit2 = i_wb_enable && (i_wb_select == i_rs2_sel);
    assign fwd1    = busy1 && wb_hit1;
    assign fwd2    = busy2 && wb_hit2;
`else
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif

    assign hazard = (busy1 && !fwd1) || (busy2 && !fwd2) || (i_rd_en && busy_d);

    assign o_req_ready = ((state == EMPTY) || i_op_ready) && !hazard;
    assign accept      = i_req_valid && o_req_ready;
    assign o_op_valid  = (state == FULL);

    assign rs1_val = fwd1 ? i_wb_data : read_of(i_rs1_sel);
    assign rs2_val = fwd2 ? i_wb_data : read_of(i_rs2_sel);

    always_comb begin
        state_n = state;
        unique case (state)
            EMPTY: if (accept) state_n = FULL;
            FULL:  if (i_op_ready && !accept) state_n = EMPTY;
            default: state_n = EMPTY;
        endcase
    end

    // Clear first so a same-edge set on the same index wins.
    always_comb begin
        busy_n = o_busy;
        for (int k = 0; k < NUM_REG; k++) begin
            if (i_wb_enable && (i_wb_select == SELECT_WIDTH'(k))) busy_n[k] = 1'b0;
            if (accept && i_rd_en && (i_rd_sel == SELECT_WIDTH'(k))) busy_n[k] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            o_busy <= '0;
        end else begin
            state  <= state_n;
            o_busy <= busy_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rs1_data <= '0;
            o_rs2_data <= '0;
            o_rd_en    <= 1'b0;
            o_rd_sel   <= '0;
        end else if (accept) begin
            o_rs1_data <= rs1_val;
            o_rs2_data <= rs2_val;
            o_rd_en    <= i_rd_en;
            o_rd_sel   <= i_rd_sel;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios plus random traffic against a reference model.
// Honours OPERAND_FETCH_BYPASS_EN to pick the expected forwarding behaviour.
module tb_operand_fetch;

    localparam int DW = 32;
    localparam int NR = 12;
    localparam int SW = (NR > 1) ? $clog2(NR) : 1;
`ifdef OPERAND_FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR*DW-1:0] reg_flat;
    logic             i_req_valid;
    logic             o_req_ready;
    logic [SW-1:0]    i_rs1_sel;
    logic [SW-1:0]    i_rs2_sel;
    logic             i_rd_en;
    logic [SW-1:0]    i_rd_sel;
    logic             i_wb_enable;
    logic [SW-1:0]    i_wb_select;
    logic [DW-1:0]    i_wb_data;
    logic             o_op_valid;
    logic             i_op_ready;
    logic [DW-1:0]    o_rs1_data;
    logic [DW-1:0]    o_rs2_data;
    logic             o_rd_en;
    logic [SW-1:0]    o_rd_sel;
    logic [NR-1:0]    o_busy;

    logic [DW-1:0] rf [NR];

    int n_checks = 0;
    int n_errors = 0;

    bit            mbusy [16];
    bit            mvalid;
    logic [DW-1:0] m1;
    logic [DW-1:0] m2;
    bit            mrd_en;
    logic [SW-1:0] mrd;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < NR; k++) reg_flat[k*DW +: DW] = rf[k];
    end

    operand_fetch #(.DATA_WIDTH(DW), .NUM_REG(NR)) dut (
        .clk(clk), .rst_n(rst_n), .i_reg_data(reg_flat),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_rs1_sel(i_rs1_sel), .i_rs2_sel(i_rs2_sel),
        .i_rd_en(i_rd_en), .i_rd_sel(i_rd_sel),
        .i_wb_enable(i_wb_enable), .i_wb_select(i_wb_select),
        .i_wb_data(i_wb_data), .o_op_valid(o_op_valid),
        .i_op_ready(i_op_ready), .o_rs1_data(o_rs1_data),
        .o_rs2_data(o_rs2_data), .o_rd_en(o_rd_en),
        .o_rd_sel(o_rd_sel), .o_busy(o_busy)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit mb(input int s);
        return (s < NR) && mbusy[s];
    endfunction

    function automatic bit fwd(input int s);
        return BYP && mb(s) && i_wb_enable && (int'(i_wb_select) == s);
    endfunction

    function automatic logic [DW-1:0] val(input int s, input bit f);
        if (s >= NR) return '0;
        if (f) return i_wb_data;
        return rf[s];
    endfunction

    function automatic logic [NR-1:0] packed_busy();
        logic [NR-1:0] p;
        for (int k = 0; k < NR; k++) p[k] = mbusy[k];
        return p;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 16; k++) mbusy[k] = 1'b0;
        mvalid = 1'b0;
    endtask

    task automatic idle();
        i_req_valid = 1'b0;
        i_rs1_sel   = '0;
        i_rs2_sel   = '0;
        i_rd_en     = 1'b0;
        i_rd_sel    = '0;
        i_wb_enable = 1'b0;
        i_wb_select = '0;
        i_wb_data   = '0;
        i_op_ready  = 1'b1;
    endtask

    // Called just after a falling edge with inputs applied; returns after the next one.
    task automatic step();
        int s1, s2, sd, sw;
        bit f1, f2, haz, rdy, acc;
        logic [DW-1:0] v1, v2;
        s1 = int'(i_rs1_sel);
        s2 = int'(i_rs2_sel);
        sd = int'(i_rd_sel);
        sw = int'(i_wb_select);
        #1;
        f1  = fwd(s1);
        f2  = fwd(s2);
        haz = (mb(s1) && !f1) || (mb(s2) && !f2) || (i_rd_en && mb(sd));
        rdy = (!mvalid || i_op_ready) && !haz;
        check("req_ready", o_req_ready, rdy);
        v1  = val(s1, f1);
        v2  = val(s2, f2);
        acc = i_req_valid && rdy;
        @(posedge clk);
        if (acc) begin
            mvalid = 1'b1;
            m1     = v1;
            m2     = v2;
            mrd_en = i_rd_en;
            mrd    = i_rd_sel;
        end else if (i_op_ready) begin
            mvalid = 1'b0;
        end
        if (i_wb_enable && sw < NR) mbusy[sw] = 1'b0;
        if (acc && i_rd_en && sd < NR) mbusy[sd] = 1'b1;
        #1;
        check("op_valid", o_op_valid, mvalid);
        check("busy", o_busy, packed_busy());
        if (mvalid) begin
            check("rs1_data", o_rs1_data, m1);
            check("rs2_data", o_rs2_data, m2);
            check("rd_en", o_rd_en, mrd_en);
            check("rd_sel", o_rd_sel, mrd);
        end
        @(negedge clk);
    endtask

    initial begin
        int start;
        rst_n = 1'b0;
        idle();
        for (int k = 0; k < NR; k++) rf[k] = DW'(k) * 32'h0101;
        model_reset();
        i_req_valid = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_valid", o_op_valid, 0);
        check("rst_rs1", o_rs1_data, 0);
        check("rst_rs2", o_rs2_data, 0);
        check("rst_rd_en", o_rd_en, 0);
        check("rst_rd_sel", o_rd_sel, 0);
        check("rst_busy", o_busy, 0);
        rst_n = 1'b1;

        rf[3] = 32'h11;
        rf[5] = 32'h22;
        i_rs1_sel = 4'd3;
        i_rs2_sel = 4'd5;
        step();
        check("basic_valid", o_op_valid, 1);
        check("basic_rs1", o_rs1_data, 32'h11);
        check("basic_rs2", o_rs2_data, 32'h22);

        i_rs1_sel = 4'd0;
        i_rs2_sel = 4'd0;
        i_rd_en   = 1'b1;
        i_rd_sel  = 4'd7;
        step();
        i_rd_en   = 1'b0;
        i_rs1_sel = 4'd7;
        repeat (2) begin
            step();
            #1;
            check("raw_stall", o_req_ready, 0);
            check("raw_busy7", o_busy[7], 1);
        end

        i_wb_enable = 1'b1;
        i_wb_select = 4'd7;
        i_wb_data   = 32'hABCD;
        #1;
        check("wb_same_cycle_ready", o_req_ready, BYP);
        step();
        if (!BYP) begin
            i_wb_enable = 1'b0;
            rf[7] = 32'hABCD;
            #1;
            check("wb_next_cycle_ready", o_req_ready, 1);
            step();
        end
        check("wb_rs1", o_rs1_data, 32'hABCD);
        i_wb_enable = 1'b0;

        rf[1] = 32'h55;
        i_rs1_sel = 4'd1;
        i_rs2_sel = 4'd1;
        step();
        rf[1] = 32'h66;
        i_op_ready = 1'b0;
        repeat (3) begin
            step();
            #1;
            check("hold_rs1", o_rs1_data, 32'h55);
            check("hold_ready", o_req_ready, 0);
        end
        i_op_ready = 1'b1;
        step();
        check("b2b_rs1", o_rs1_data, 32'h66);

        i_rs1_sel   = 4'd0;
        i_rs2_sel   = 4'd0;
        i_rd_en     = 1'b1;
        i_rd_sel    = 4'd4;
        i_wb_enable = 1'b1;
        i_wb_select = 4'd4;
        step();
        check("set_wins", o_busy[4], 1);

        i_wb_enable = 1'b0;
        i_rd_sel    = 4'd9;
        i_op_ready  = 1'b0;
        step();
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", o_op_valid, 0);
        check("midrst_busy", o_busy, 0);
        model_reset();
        idle();
        @(negedge clk);
        rst_n = 1'b1;

        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < NR; k++) rf[k] = $urandom;
            i_req_valid = ($urandom_range(0, 9) < 7);
            i_rs1_sel   = SW'($urandom_range(0, 15));
            i_rs2_sel   = SW'($urandom_range(0, 15));
            i_rd_en     = $urandom_range(0, 1);
            i_rd_sel    = SW'($urandom_range(0, 15));
            i_op_ready  = ($urandom_range(0, 9) < 7);
            i_wb_enable = ($urandom_range(0, 9) < 6);
            i_wb_data   = $urandom;
            i_wb_select = SW'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                start = $urandom_range(0, NR - 1);
                for (int j = NR - 1; j >= 0; j--) begin
                    if (mbusy[(start + j) % NR]) i_wb_select = SW'((start + j) % NR);
                end
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
